// File: rtl/lenet_layer_sched.sv
// lenet_layer_sched: frame scheduler sequencing conv, FC1 and FC2 with a result handshake,
// a wrapping completed-frame counter and a per-layer watchdog.
module lenet_layer_sched #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FRAME_W        = 16
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               img_valid,
  output logic               img_ready,
  input  logic               abort,
  input  logic               err_clr,
  output logic               conv_start,
  input  logic               conv_done,
  input  logic               mem_sel,
  input  logic               fc1_done,
  input  logic               fc2_done,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               result_bank,
  output logic               busy,
  output logic [2:0]         state,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CONV = 3'd1;
  localparam logic [2:0] S_FC1  = 3'd2;
  localparam logic [2:0] S_FC2  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]           r_state, w_next;
  logic [1:0]           r_err_code, w_err_code;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic                 r_conv_start, r_result_bank;
  logic                 w_active, w_exp_done, w_unexp, w_proto, w_timeout, w_clr, w_start, w_deliver;

  always_comb begin
    w_active   = (r_state == S_CONV) || (r_state == S_FC1) || (r_state == S_FC2);
    w_exp_done = (r_state == S_CONV) ? conv_done : (r_state == S_FC1) ? fc1_done :
                 (r_state == S_FC2) ? fc2_done : 1'b0;
    w_unexp    = (conv_done && r_state != S_CONV) || (fc1_done && r_state != S_FC1) ||
                 (fc2_done && r_state != S_FC2);
    w_proto    = w_active && w_unexp;
    // a done landing on the last allowed cycle still counts as on time
    w_timeout  = w_active && !w_exp_done && (r_wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    w_clr      = abort || (r_state == S_ERR && err_clr);
    w_start    = !abort && r_state == S_IDLE && img_valid;
    w_deliver  = !abort && r_state == S_DONE && result_ready;
    w_next     = w_clr ? S_IDLE : (w_proto || w_timeout) ? S_ERR : w_start ? S_CONV :
                 (w_active && w_exp_done) ? r_state + 3'd1 : w_deliver ? S_IDLE : r_state;
    w_err_code = w_clr ? 2'b00 : w_proto ? 2'b10 : w_timeout ? 2'b01 : r_err_code;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state       <= S_IDLE;
      r_err_code    <= 2'b00;
      r_wd          <= '0;
      r_frame_cnt   <= '0;
      r_conv_start  <= 1'b0;
      r_result_bank <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_err_code   <= w_err_code;
      r_conv_start <= w_start;
      r_wd         <= (w_next != r_state || !w_active) ? '0 : r_wd + 1'b1;
      if (r_state == S_CONV && w_next == S_FC1) r_result_bank <= mem_sel;
      if (w_deliver) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign state        = r_state;
  assign img_ready    = r_state == S_IDLE;
  assign conv_start   = r_conv_start;
  assign result_valid = r_state == S_DONE;
  assign result_bank  = r_result_bank;
  assign busy         = w_active || r_state == S_DONE;
  assign err          = r_state == S_ERR;
  assign err_code     = r_err_code;
  assign frame_cnt    = r_frame_cnt;
endmodule
